// File: rtl/jtag_master_pkg.sv
// Shared encodings for the JTAG master: operation codes, FSM states and the
// fixed TMS header/trailer patterns (stored LSB first, one bit per TCK).
package jtag_pkg;

  localparam logic [1:0] OP_RST  = 2'b00;
  localparam logic [1:0] OP_IR   = 2'b01;
  localparam logic [1:0] OP_DR   = 2'b10;
  localparam logic [1:0] OP_IDLE = 2'b11;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_HDR     = 3'd1;
  localparam logic [2:0] ST_SHIFT   = 3'd2;
  localparam logic [2:0] ST_TRAILER = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // TAP reset: 1,1,1,1,1,0 lands in Run-Test/Idle from any state
  localparam logic [5:0] HDR_RST_PAT = 6'b011111;
  localparam logic [5:0] HDR_RST_LEN = 6'd6;
  // IR scan: Select-DR, Select-IR, Capture-IR, Shift-IR
  localparam logic [5:0] HDR_IR_PAT  = 6'b000011;
  localparam logic [5:0] HDR_IR_LEN  = 6'd4;
  // DR scan: Select-DR, Capture-DR, Shift-DR
  localparam logic [5:0] HDR_DR_PAT  = 6'b000001;
  localparam logic [5:0] HDR_DR_LEN  = 6'd3;
  // After Exit1: Update, Run-Test/Idle
  localparam logic [1:0] TRL_PAT     = 2'b01;
  localparam logic [5:0] TRL_LEN     = 6'd2;

  function automatic logic [5:0] hdr_pat(input logic [1:0] op);
    case (op)
      OP_RST:  return HDR_RST_PAT;
      OP_IR:   return HDR_IR_PAT;
      OP_DR:   return HDR_DR_PAT;
      default: return 6'b0;
    endcase
  endfunction

  function automatic logic [5:0] hdr_len(input logic [1:0] op);
    case (op)
      OP_RST:  return HDR_RST_LEN;
      OP_IR:   return HDR_IR_LEN;
      OP_DR:   return HDR_DR_LEN;
      default: return 6'd0;
    endcase
  endfunction

endpackage

// File: rtl/jtag_master_tck_gen.sv
// TCK divider: a period is 2*CLK_DIV clock cycles, low half first. The
// strobes mark the clock edge that drives TCK low (tck_fall) or high
// (tck_rise). The counter is held at zero while run is low, so the first
// strobe after run rises is always a fall.
module tck_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tck,
  output logic tck_fall,
  output logic tck_rise
);

  localparam int CW = $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_RISE = CW'(CLK_DIV);

  logic [CW-1:0] cnt;

  assign tck_fall = run && (cnt == '0);
  assign tck_rise = run && (cnt == CNT_RISE);

  // Divider counter and TCK level, cleared while stopped
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      cnt <= '0;
      tck <= 1'b0;
    end else begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
      if (tck_fall)      tck <= 1'b0;
      else if (tck_rise) tck <= 1'b1;
    end
  end

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG master. Runs one command (TAP reset, IR scan, DR scan or
// idle run) from Run-Test/Idle back to Run-Test/Idle and returns the TDO
// bits captured during the shift phase.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int MAX_LEN = 32
) (
  input  logic               ICLK,
  input  logic               TRST,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [5:0]         cmd_len,
  input  logic [MAX_LEN-1:0] cmd_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               busy,
  output logic               TCK,
  output logic               TMS,
  output logic               TDI,
  input  logic               TDO
);

  localparam int IDX_W = $clog2(MAX_LEN);

  logic [2:0]         state;
  logic [1:0]         op_q;
  logic [5:0]         len_q;
  logic [5:0]         idx;
  logic               fin_q;    // last bit is out; the next fall closes its period
  logic               cap_en;   // bit on the wire is a scan shift bit
  logic [IDX_W-1:0]   cap_idx;
  logic [MAX_LEN-1:0] data_q;
  logic [MAX_LEN-1:0] cap_q;
  logic               run;
  logic               tck_fall;
  logic               tck_rise;
  logic [5:0]         hpat;
  logic [5:0]         hlen;
  logic               is_scan;

  // Zero means one bit; anything beyond the port width is cut to the width
  function automatic logic [5:0] clamp_len(input logic [5:0] len);
    if (len == 6'd0) return 6'd1;
    if (int'(len) > MAX_LEN) return 6'(MAX_LEN);
    return len;
  endfunction

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = !cmd_ready;
  assign rsp_valid = (state == ST_DONE);
  assign run       = (state == ST_HDR) || (state == ST_SHIFT) || (state == ST_TRAILER);
  assign hpat      = hdr_pat(op_q);
  assign hlen      = hdr_len(op_q);
  assign is_scan   = (op_q == OP_IR) || (op_q == OP_DR);

  tck_gen #(.CLK_DIV(CLK_DIV)) u_tck_gen (
    .clk      (ICLK),
    .rst      (TRST),
    .run      (run),
    .tck      (TCK),
    .tck_fall (tck_fall),
    .tck_rise (tck_rise)
  );

  // Command sequencer: one TMS/TDI bit per TCK fall, phase by phase
  always_ff @(posedge ICLK) begin
    if (TRST) begin
      state    <= ST_IDLE;
      idx      <= '0;
      fin_q    <= 1'b0;
      cap_en   <= 1'b0;
      TMS      <= 1'b1;
      TDI      <= 1'b0;
      rsp_data <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            op_q  <= cmd_op;
            len_q <= clamp_len(cmd_len);
            idx   <= '0;
            fin_q <= 1'b0;
            state <= (cmd_op == OP_IDLE) ? ST_SHIFT : ST_HDR;
          end
        end
        ST_HDR, ST_SHIFT, ST_TRAILER: begin
          if (tck_fall) begin
            cap_en <= 1'b0;
            TDI    <= 1'b0;
            if (fin_q) begin
              state    <= ST_DONE;
              rsp_data <= cap_q;
            end else if (state == ST_HDR) begin
              TMS <= hpat[idx[2:0]];
              if (idx == hlen - 6'd1) begin
                idx <= '0;
                if (op_q == OP_RST) fin_q <= 1'b1;
                else                state <= ST_SHIFT;
              end else begin
                idx <= idx + 6'd1;
              end
            end else if (state == ST_SHIFT) begin
              TMS     <= is_scan && (idx == len_q - 6'd1);
              TDI     <= is_scan && data_q[idx[IDX_W-1:0]];
              cap_en  <= is_scan;
              cap_idx <= idx[IDX_W-1:0];
              if (idx == len_q - 6'd1) begin
                idx <= '0;
                if (is_scan) state <= ST_TRAILER;
                else         fin_q <= 1'b1;
              end else begin
                idx <= idx + 6'd1;
              end
            end else begin
              TMS <= TRL_PAT[idx[0]];
              if (idx == TRL_LEN - 6'd1) fin_q <= 1'b1;
              else                       idx   <= idx + 6'd1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Scan data: latch TDI bits at accept, collect TDO on shift-bit rises
  always_ff @(posedge ICLK) begin
    if (cmd_ready && cmd_valid) begin
      data_q <= cmd_data;
      cap_q  <= '0;
    end else if (tck_rise && cap_en) begin
      cap_q[cap_idx] <= TDO;
    end
  end

endmodule
